redmule_tcdm_responder: RTL and testbench
=========================================

REDMULE_TCDM_RESPONDER -- requirements
Module: redmule_tcdm_responder

Interface
REQ-001 Parameter DATA_W, default redmule_pkg::DATA_W (544): data width of the wide port in bits.
REQ-002 Parameter DEPTH, default 256: number of DATA_W-bit words in the internal memory; power of two, at least 2.
REQ-003 Parameter BASE_ADDR, default 32'h0: byte address of word 0.
REQ-004 Port clk_i, input, 1: single clock.
REQ-005 Port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 Port stall_i, input, 1: forces gnt low while high (contention injection).
REQ-007 Port req_i, input, redmule_default_data_req_t: initiator request (req, wen, be, boffs, add, data, lrdy, user).
REQ-008 Port rsp_o, output, redmule_default_data_rsp_t: response (gnt, r_valid, r_data, r_opc, r_user).
REQ-009 Port busy_o, output, 1: high while any accepted read has not yet been delivered.

Function
REQ-010 Handshake: a request is accepted in a cycle iff req=1 and gnt=1; gnt SHALL be combinational and equal req & ~stall_i & (occupancy + in_flight < 2).
- occupancy: response FIFO entries.
- in_flight: accepted read in the memory stage.
REQ-011 wen=1 marks a read and wen=0 marks a write, per HCI convention.
REQ-012 Word index = (add - BASE_ADDR) >> log2(DATA_W/8); the access is in range iff BASE_ADDR <= add < BASE_ADDR + DEPTH*(DATA_W/8).
REQ-013 Accepted in-range write: memory bytes with be[i]=1 SHALL update at the accepting clock edge; other bytes are unchanged; no response is generated.
REQ-014 Accepted out-of-range write: dropped; sets sticky flag err_q, which is internal and observable in simulation.
REQ-015 Accepted read: memory is read in the accept cycle and registered. At the next edge an entry {data, opc, user} is pushed into a 2-entry response FIFO.
- Minimum read latency is 1 cycle: r_valid is high in the cycle after the accept.
REQ-016 Out-of-range read: pushes r_data=0 and r_opc=1; in-range reads push r_opc=0.
REQ-017 r_user SHALL echo req.user of the originating read.
REQ-018 boffs and lrdy-independent fields are ignored for addressing; all DATA_W/32 lanes access the same word.
REQ-019 r_valid = FIFO not empty; r_data/r_opc/r_user = FIFO head. A head entry is popped iff r_valid & req.lrdy.
REQ-020 While r_valid=1 and lrdy=0, head fields SHALL stay stable.
REQ-021 Responses SHALL be returned in acceptance order; a FIFO push and pop in the same cycle leave occupancy unchanged.
REQ-022 Read-after-write: a read accepted the cycle after a write to the same word returns the written data.
REQ-023 A read and a write cannot be accepted in the same cycle (single port), so no same-cycle collision exists.
REQ-024 busy_o = in_flight | (occupancy != 0).

Reset
REQ-025 While rst_i=1 at a clock edge: FIFO is emptied, in_flight=0, err_q=0.
REQ-026 Outputs during and after reset: gnt follows REQ-010, r_valid=0, r_opc=0, r_data=0, r_user=0, busy_o=0.
REQ-027 Reset mid-operation discards in-flight and queued responses. Memory contents are not reset.

Structure
REQ-028 Response entry struct (data, opc, user) SHALL be defined in redmule_pkg next to the existing data request/response types.
REQ-029 The 2-entry FIFO SHALL be a sub-module, redmule_rsp_fifo (parameterised entry type, depth 2, push/pop/full/empty).

Verification
REQ-030 Write add=BASE_ADDR+0x44 with all-ones be and data=D, then read the same address with lrdy=1 -> gnt=1 both cycles; r_valid 1 cycle after the read; r_data=D; r_opc=0.
REQ-031 Write with only be[0]=1 and data byte 0 = 8'hA5 over a word holding 8'h00 in every byte -> readback shows 8'hA5 in byte 0 only.
REQ-032 Three back-to-back reads with lrdy=0 -> first two granted, third sees gnt=0; after lrdy=1 responses arrive in order with the correct user tags, and the third is then granted.
REQ-033 Read at BASE_ADDR + DEPTH*(DATA_W/8) -> r_valid with r_data=0 and r_opc=1; an out-of-range write sets err_q and leaves memory unchanged.
REQ-034 stall_i=1 for 5 cycles with req=1 -> gnt=0 throughout and no response; after stall drops, the request is granted.
REQ-035 rst_i asserted while 2 responses are queued -> next cycle r_valid=0 and busy_o=0; previously written memory data is still readable.

Source files
------------

// File: rtl/redmule_pkg.sv
// Shared HCI wide-port request/response types and the response entry type
// used by the TCDM responder model.
package redmule_pkg;

    localparam int unsigned DATA_W  = 544;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned BOFFS_W = DATA_W / 32;
    localparam int unsigned USER_W  = 8;

    typedef struct packed {
        logic                req;
        logic                wen;
        logic [BE_W-1:0]     be;
        logic [BOFFS_W-1:0]  boffs;
        logic [ADDR_W-1:0]   add;
        logic [DATA_W-1:0]   data;
        logic                lrdy;
        logic [USER_W-1:0]   user;
    } redmule_default_data_req_t;

    typedef struct packed {
        logic                gnt;
        logic                r_valid;
        logic [DATA_W-1:0]   r_data;
        logic                r_opc;
        logic [USER_W-1:0]   r_user;
    } redmule_default_data_rsp_t;

    typedef struct packed {
        logic [DATA_W-1:0]   data;
        logic                opc;
        logic [USER_W-1:0]   user;
    } redmule_rsp_entry_t;

endpackage

// File: rtl/redmule_rsp_fifo.sv
// Small synchronous FIFO holding read responses; entry storage is not reset,
// only the pointers and occupancy are.
module redmule_rsp_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  T                         i_data,
    input  logic                     i_pop,
    output T                         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    T                r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + PW'(1);
            if (i_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rptr];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;

endmodule

// File: rtl/redmule_tcdm_responder.sv
// Single-port TCDM memory model answering HCI wide-port requests, with
// contention injection and a 2-entry response queue behind a read stage.
module redmule_tcdm_responder #(
    parameter int unsigned DATA_W    = redmule_pkg::DATA_W,
    parameter int unsigned DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   stall_i,
    input  redmule_pkg::redmule_default_data_req_t req_i,
    output redmule_pkg::redmule_default_data_rsp_t rsp_o,
    output logic                                   busy_o
);

    import redmule_pkg::*;

    localparam int unsigned BYTES   = DATA_W / 8;
    // Word stride rounded up to a power of two so the index is a plain slice.
    localparam int unsigned OFFS_SH = $clog2(BYTES);
    localparam int unsigned IDX_W   = $clog2(DEPTH);
    localparam logic [31:0] RANGE   = 32'(DEPTH * BYTES);
    localparam int unsigned FIFO_D  = 2;

    logic [DATA_W-1:0]        r_mem [DEPTH];
    redmule_rsp_entry_t       r_stage;
    logic                     r_in_flight;
    logic                     err_q;

    logic [31:0]              w_off;
    logic                     w_in_range;
    logic [IDX_W-1:0]         w_idx;
    logic [$clog2(FIFO_D):0]  w_count;
    logic [2:0]               w_load;
    logic                     w_gnt;
    logic                     w_acc_rd;
    logic                     w_acc_wr;
    logic                     w_fifo_empty;
    logic                     w_fifo_full;
    logic                     w_fifo_push;
    logic                     w_fifo_pop;
    logic                     w_valid;
    redmule_rsp_entry_t       w_head;
    redmule_rsp_entry_t       w_out;
    logic                     w_unused;

    assign w_off      = req_i.add - BASE_ADDR;
    assign w_in_range = (req_i.add >= BASE_ADDR) && (w_off < RANGE);
    assign w_idx      = w_off[OFFS_SH +: IDX_W];

    assign w_load   = {1'b0, w_count} + {2'b00, r_in_flight};
    assign w_gnt    = req_i.req & ~stall_i & (w_load < 3'd2);
    assign w_acc_rd = w_gnt &  req_i.wen;
    assign w_acc_wr = w_gnt & ~req_i.wen;

    always_ff @(posedge clk_i) begin
        if (w_acc_wr && w_in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (req_i.be[i]) r_mem[w_idx][8*i +: 8] <= req_i.data[8*i +: 8];
            end
        end
    end

    // Read stage: sample memory in the accept cycle
    always_ff @(posedge clk_i) begin
        if (w_acc_rd) begin
            r_stage.data <= w_in_range ? r_mem[w_idx] : '0;
            r_stage.opc  <= ~w_in_range;
            r_stage.user <= req_i.user;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_in_flight <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            r_in_flight <= w_acc_rd;
            if (w_acc_wr && !w_in_range) err_q <= 1'b1;
        end
    end

    // The stage entry is always younger than anything already queued, so it
    // is presented directly only when the queue is empty.
    assign w_valid     = r_in_flight | ~w_fifo_empty;
    assign w_fifo_pop  = ~w_fifo_empty & req_i.lrdy;
    assign w_fifo_push = r_in_flight & ~(w_fifo_empty & req_i.lrdy);
    assign w_out       = w_fifo_empty ? r_stage : w_head;

    redmule_rsp_fifo #(
        .T     (redmule_rsp_entry_t),
        .DEPTH (FIFO_D)
    ) u_rsp_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_fifo_push),
        .i_data  (r_stage),
        .i_pop   (w_fifo_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    always_comb begin
        rsp_o         = '0;
        rsp_o.gnt     = w_gnt;
        rsp_o.r_valid = w_valid;
        if (w_valid) begin
            rsp_o.r_data = w_out.data;
            rsp_o.r_opc  = w_out.opc;
            rsp_o.r_user = w_out.user;
        end
    end

    assign busy_o   = r_in_flight | ~w_fifo_empty;
    assign w_unused = ^{req_i.boffs, w_fifo_full};

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Directed bench for the TCDM responder: handshake, byte enables, queueing,
// out-of-range handling, stall injection and reset behaviour.
module tb_redmule_tcdm_responder;
    import redmule_pkg::*;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      stall;
    redmule_default_data_req_t rq;
    redmule_default_data_rsp_t rs;
    logic                      busy;

    int errs   = 0;
    int checks = 0;

    logic [DATA_W-1:0] d1;
    logic [DATA_W-1:0] ones;
    logic [DATA_W-1:0] a5_ones;
    logic [DATA_W-1:0] a5_only;
    logic [BE_W-1:0]   be_all;
    logic [BE_W-1:0]   be_b0;

    always #5 clk = ~clk;

    redmule_tcdm_responder #(
        .DATA_W    (DATA_W),
        .DEPTH     (256),
        .BASE_ADDR (32'h0)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .stall_i (stall),
        .req_i   (rq),
        .rsp_o   (rs),
        .busy_o  (busy)
    );

    task automatic check(input string tag, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic req, input logic wen, input logic [31:0] add,
                       input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be,
                       input logic [USER_W-1:0] user, input logic lrdy);
        rq.req  = req;
        rq.wen  = wen;
        rq.add  = add;
        rq.data = data;
        rq.be   = be;
        rq.user = user;
        rq.lrdy = lrdy;
        #2;
    endtask

    initial begin
        d1      = {17{32'h1234_5678}};
        ones    = '1;
        a5_ones = {ones[DATA_W-1:8], 8'hA5};
        a5_only = '0;
        a5_only[7:0] = 8'hA5;
        be_all  = '1;
        be_b0   = '0;
        be_b0[0] = 1'b1;

        rst   = 1'b1;
        stall = 1'b0;
        rq    = '0;
        rq.lrdy = 1'b1;
        step();
        step();
        check("rst_valid", rs.r_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_data",  rs.r_data, 0);
        check("rst_user",  rs.r_user, 0);
        check("rst_opc",   rs.r_opc, 0);
        check("rst_err",   dut.err_q, 0);
        drv(1, 1, 32'h0, '0, '0, 8'h00, 1);
        check("rst_gnt", rs.gnt, 1);
        step();
        rst = 1'b0;
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("post_rst_valid", rs.r_valid, 0);

        // write then read same word
        step();
        drv(1, 0, 32'h44, d1, be_all, 8'h00, 1);
        check("wr_gnt", rs.gnt, 1);
        step();
        drv(1, 1, 32'h44, '0, '0, 8'h11, 1);
        check("rd_gnt", rs.gnt, 1);
        check("rd_valid_early", rs.r_valid, 0);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("rd_valid", rs.r_valid, 1);
        check("rd_data", rs.r_data, d1);
        check("rd_opc", rs.r_opc, 0);
        check("rd_user", rs.r_user, 8'h11);
        check("rd_busy", busy, 1);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("rd_done_valid", rs.r_valid, 0);
        check("rd_done_busy", busy, 0);

        // byte-enable masking on word 1
        step();
        drv(1, 0, 32'h80, '0, be_all, 8'h00, 1);
        step();
        drv(1, 0, 32'h80, a5_ones, be_b0, 8'h00, 1);
        step();
        drv(1, 1, 32'h80, '0, '0, 8'h22, 1);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("be_data", rs.r_data, a5_only);

        // three reads with lrdy low
        step();
        drv(1, 1, 32'h44, '0, '0, 8'h01, 0);
        check("q_gnt1", rs.gnt, 1);
        step();
        drv(1, 1, 32'h80, '0, '0, 8'h02, 0);
        check("q_gnt2", rs.gnt, 1);
        check("q_head_user_a", rs.r_user, 8'h01);
        step();
        drv(1, 1, 32'h0, '0, '0, 8'h03, 0);
        check("q_gnt3_blocked", rs.gnt, 0);
        check("q_hold_valid", rs.r_valid, 1);
        check("q_hold_user", rs.r_user, 8'h01);
        step();
        drv(1, 1, 32'h0, '0, '0, 8'h03, 0);
        check("q_hold_data", rs.r_data, d1);
        check("q_gnt3_still", rs.gnt, 0);
        step();
        drv(1, 1, 32'h0, '0, '0, 8'h03, 1);
        check("q_gnt3_full", rs.gnt, 0);
        check("q_out1_user", rs.r_user, 8'h01);
        check("q_out1_data", rs.r_data, d1);
        step();
        drv(1, 1, 32'h0, '0, '0, 8'h03, 1);
        check("q_gnt3_now", rs.gnt, 1);
        check("q_out2_user", rs.r_user, 8'h02);
        check("q_out2_data", rs.r_data, a5_only);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("q_out3_valid", rs.r_valid, 1);
        check("q_out3_user", rs.r_user, 8'h03);
        check("q_out3_data", rs.r_data, d1);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("q_empty", rs.r_valid, 0);

        // out-of-range read and write
        step();
        drv(1, 1, 32'h4400, '0, '0, 8'h05, 1);
        check("oor_rd_gnt", rs.gnt, 1);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("oor_valid", rs.r_valid, 1);
        check("oor_data", rs.r_data, 0);
        check("oor_opc", rs.r_opc, 1);
        check("oor_user", rs.r_user, 8'h05);
        check("oor_rd_no_err", dut.err_q, 0);
        step();
        drv(1, 0, 32'h4400, ones, be_all, 8'h00, 1);
        step();
        drv(1, 1, 32'h44, '0, '0, 8'h06, 1);
        check("oor_err", dut.err_q, 1);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("oor_mem_kept", rs.r_data, d1);
        check("oor_ok_opc", rs.r_opc, 0);

        // stall injection
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            drv(1, 1, 32'h80, '0, '0, 8'h07, 1);
            check("stall_gnt", rs.gnt, 0);
            check("stall_valid", rs.r_valid, 0);
        end
        step();
        stall = 1'b0;
        drv(1, 1, 32'h80, '0, '0, 8'h07, 1);
        check("unstall_gnt", rs.gnt, 1);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("unstall_valid", rs.r_valid, 1);
        check("unstall_user", rs.r_user, 8'h07);
        check("unstall_data", rs.r_data, a5_only);

        // reset with two responses queued
        step();
        drv(1, 1, 32'h44, '0, '0, 8'h08, 0);
        step();
        drv(1, 1, 32'h80, '0, '0, 8'h09, 0);
        check("pre_rst_gnt2", rs.gnt, 1);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 0);
        check("pre_rst_busy", busy, 1);
        check("pre_rst_valid", rs.r_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("mid_rst_valid", rs.r_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_data", rs.r_data, 0);
        check("mid_rst_user", rs.r_user, 0);
        step();
        drv(1, 1, 32'h44, '0, '0, 8'h0A, 1);
        step();
        drv(0, 1, 32'h0, '0, '0, 8'h00, 1);
        check("post_rst_mem", rs.r_data, d1);
        check("post_rst_user", rs.r_user, 8'h0A);
        step();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
